// File: rtl/opf_pkg.sv
// Shared definitions for the operand-fetch/writeback stage: opcodes,
// instruction field positions and the E1 pipeline record.
package opf_pkg;

  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned DATA_W    = 16;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_MSB = 8;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_MSB = 5;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned IMM_MSB = 8;

  typedef struct packed {
    logic [3:0]           opcode;
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    src1;
    logic [DATA_W-1:0]    src2;
    logic [DATA_W-1:0]    imm;
    logic                 writes_rd;
  } e1_t;

  typedef enum logic {
    E1_EMPTY = 1'b0,
    E1_FULL  = 1'b1
  } e1_state_e;

  // Only ALU opcodes up to LDI write back, and r0 is never a real destination.
  function automatic logic writes_reg(input logic [3:0] op, input logic [REG_IDX_W-1:0] rd);
    return (op <= OP_LDI) && (rd != '0);
  endfunction

endpackage

// File: rtl/operand_fetch_wb_if.sv
// Instruction-issue and result-commit handshakes of operand_fetch_wb.
interface operand_fetch_wb_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_rd;

  modport master (
    output instr_valid, instr, res_ready,
    input  instr_ready, res_valid, res_data, res_rd
  );

  modport slave (
    input  instr_valid, instr, res_ready,
    output instr_ready, res_valid, res_data, res_rd
  );
endinterface

// File: rtl/opf_regfile.sv
// 8 x 16 register file: one write port, three combinational read ports,
// r0 reads as zero.
module opf_regfile
  import opf_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [REG_IDX_W-1:0] rd1_addr,
  output logic [DATA_W-1:0]    rd1_data,
  input  logic [REG_IDX_W-1:0] rd2_addr,
  output logic [DATA_W-1:0]    rd2_data,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd1_data = (rd1_addr == '0) ? '0 : regs[rd1_addr];
    rd2_data = (rd2_addr == '0) ? '0 : regs[rd2_addr];
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: rtl/operand_fetch_wb.sv
// Operand fetch / writeback stage around the external ALU with one pipeline
// register (E1). Define OPF_FORWARD_EN to forward instead of stalling on hazards.
module operand_fetch_wb
  import opf_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  operand_fetch_wb_if.slave    bus,
  output logic [3:0]           alu_opcode,
  output logic [DATA_W-1:0]    alu_src1,
  output logic [DATA_W-1:0]    alu_src2,
  output logic [DATA_W-1:0]    alu_immediate,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_carry,
  output logic                 carry_flag,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);

  e1_state_e state_q, state_d;
  e1_t       e1_q, e1_d;

  logic [3:0]           dec_op;
  logic [REG_IDX_W-1:0] dec_rd, dec_rs1, dec_rs2;
  logic [DATA_W-1:0]    dec_imm;
  logic [DATA_W-1:0]    rf_rs1, rf_rs2, op_src1, op_src2;
  logic                 accept, commit, hazard, wr_en;

  assign dec_op  = bus.instr[OPC_MSB:OPC_LSB];
  assign dec_rd  = bus.instr[RD_MSB:RD_LSB];
  assign dec_rs1 = bus.instr[RS1_MSB:RS1_LSB];
  assign dec_rs2 = bus.instr[RS2_MSB:RS2_LSB];
  assign dec_imm = {{7{bus.instr[IMM_MSB]}}, bus.instr[IMM_MSB:0]};

  assign commit = (state_q == E1_FULL) && bus.res_ready;
  assign wr_en  = commit && e1_q.writes_rd;

  opf_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (e1_q.rd),
    .wr_data  (alu_result),
    .rd1_addr (dec_rs1),
    .rd1_data (rf_rs1),
    .rd2_addr (dec_rs2),
    .rd2_data (rf_rs2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // writes_rd already excludes r0, so a match implies a nonzero source index.
`ifdef OPF_FORWARD_EN
  assign op_src1 = (wr_en && (dec_rs1 == e1_q.rd)) ? alu_result : rf_rs1;
  assign op_src2 = (wr_en && (dec_rs2 == e1_q.rd)) ? alu_result : rf_rs2;
  assign hazard  = 1'b0;
`else
  assign op_src1 = rf_rs1;
  assign op_src2 = rf_rs2;
  assign hazard  = wr_en && ((dec_rs1 == e1_q.rd) || (dec_rs2 == e1_q.rd));
`endif

  assign bus.instr_ready = ((state_q == E1_EMPTY) || commit) && !hazard;
  assign accept          = bus.instr_valid && bus.instr_ready;

  always_comb begin
    state_d = state_q;
    e1_d    = e1_q;
    if (accept) begin
      state_d        = E1_FULL;
      e1_d.opcode    = dec_op;
      e1_d.rd        = dec_rd;
      e1_d.src1      = op_src1;
      e1_d.src2      = op_src2;
      e1_d.imm       = dec_imm;
      e1_d.writes_rd = writes_reg(dec_op, dec_rd);
    end else if (commit) begin
      state_d = E1_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= E1_EMPTY;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e1_q    <= e1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag <= 1'b0;
    end else if (commit && (e1_q.opcode == OP_SUB)) begin
      carry_flag <= alu_carry;
    end
  end

  assign alu_opcode    = e1_q.opcode;
  assign alu_src1      = e1_q.src1;
  assign alu_src2      = e1_q.src2;
  assign alu_immediate = e1_q.imm;
  assign bus.res_valid = (state_q == E1_FULL);
  assign bus.res_data  = alu_result;
  assign bus.res_rd    = e1_q.rd;

endmodule
